// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-requester memory arbiter.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_idx_e;

    function automatic req_idx_e other_req(input req_idx_e r);
        return (r == REQ_CPU) ? REQ_DMA : REQ_CPU;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave = arbiter view, master = requesters plus memory (testbench view).
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
);
    logic              req_c;
    logic              req_d;
    logic              we_c;
    logic              we_d;
    logic [ADDR_W-1:0] addr_c;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] wdata_d;
    logic              done_c;
    logic              done_d;
    logic [DATA_W-1:0] rdata_c;
    logic [DATA_W-1:0] rdata_d;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req_c, req_d, we_c, we_d, addr_c, addr_d, wdata_c, wdata_d, mem_rdata,
        output done_c, done_d, rdata_c, rdata_d, mem_addr, mem_write, mem_wdata, busy
    );

    modport master (
        output req_c, req_d, we_c, we_d, addr_c, addr_d, wdata_c, wdata_d, mem_rdata,
        input  done_c, done_d, rdata_c, rdata_d, mem_addr, mem_write, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between CPU and DMA requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise CPU has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     req_c,
    input  logic     req_d,
    input  req_idx_e last,
    output req_idx_e winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = REQ_CPU;
        if (req_c && req_d) begin
            // Contention: whoever was not granted last goes first.
            winner = other_req(last);
        end else if (req_d) begin
            winner = REQ_DMA;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        winner = REQ_CPU;
        if (!req_c && req_d) begin
            winner = REQ_DMA;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> ACCESS -> DONE, one access per 3 cycles.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention handling (default: CPU priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    req_idx_e          win_q;
    req_idx_e          last_q;
    req_idx_e          winner;
    logic              grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    mem_arb_pick u_pick (
        .req_c  (bus.req_c),
        .req_d  (bus.req_d),
        .last   (last_q),
        .winner (winner)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_c || bus.req_d) begin
                    state_d = ACCESS;
                    grant   = 1'b1;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_we    = bus.we_c;
        sel_addr  = bus.addr_c;
        sel_wdata = bus.wdata_c;
        if (winner == REQ_DMA) begin
            sel_we    = bus.we_d;
            sel_addr  = bus.addr_d;
            sel_wdata = bus.wdata_d;
        end
    end

    // The request is captured once at the grant edge; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= REQ_CPU;
            last_q  <= REQ_DMA;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                win_q   <= winner;
                last_q  <= winner;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

    always_comb begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_write = 1'b0;
        bus.done_c    = 1'b0;
        bus.done_d    = 1'b0;
        bus.rdata_c   = '0;
        bus.rdata_d   = '0;
        bus.busy      = (state_q != IDLE);
        if (state_q == ACCESS) begin
            bus.mem_write = we_q;
        end
        if (state_q == DONE) begin
            if (win_q == REQ_CPU) begin
                bus.done_c = 1'b1;
                if (!we_q) bus.rdata_c = bus.mem_rdata;
            end else begin
                bus.done_d = 1'b1;
                if (!we_q) bus.rdata_d = bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-schedule model plus directed literal checks.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way as the design build.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous memory with one-cycle registered read.
    bit   [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] mem_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    always @(posedge clock) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        mem_rdata_q <= mem[bus.mem_addr];
    end

    // Reference model: one in-flight transaction with ACCESS at cycle acc, DONE at acc+1.
    bit   [DW-1:0] ref_mem     [0:(1<<AW)-1];
    bit            ref_unknown [0:(1<<AW)-1];
    int            cyc = 0;
    bit            act = 1'b0;
    int            acc = 0;
    req_idx_e      m_who = REQ_CPU;
    req_idx_e      m_last = REQ_DMA;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        bit busy_prev;
        bit rc;
        bit rd;
        cyc++;
        rc = bus.req_c;
        rd = bus.req_d;
        busy_prev = act && ((cyc - 1 == acc) || (cyc - 1 == acc + 1));
        if (reset) begin
            if (act && (cyc - 1 == acc) && m_we) ref_unknown[m_addr] = 1'b1;
            act    = 1'b0;
            m_last = REQ_DMA;
        end else begin
            if (act && (cyc - 1 == acc) && m_we) begin
                ref_mem[m_addr]     = m_wdata;
                ref_unknown[m_addr] = 1'b0;
            end
            if (!busy_prev && (rc || rd)) begin
                m_who = rc ? REQ_CPU : REQ_DMA;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (rc && rd) m_who = (m_last == REQ_CPU) ? REQ_DMA : REQ_CPU;
`endif
                m_we    = (m_who == REQ_CPU) ? bus.we_c : bus.we_d;
                m_addr  = (m_who == REQ_CPU) ? bus.addr_c : bus.addr_d;
                m_wdata = (m_who == REQ_CPU) ? bus.wdata_c : bus.wdata_d;
                m_last  = m_who;
                act     = 1'b1;
                acc     = cyc;
            end
        end
    endtask

    task automatic check_outputs();
        bit in_acc;
        bit in_done;
        in_acc  = act && (cyc == acc);
        in_done = act && (cyc == acc + 1);
        chk("busy", 32'(bus.busy), 32'(in_acc || in_done));
        chk("mem_write", 32'(bus.mem_write), 32'(in_acc && m_we));
        chk("done_c", 32'(bus.done_c), 32'(in_done && m_who == REQ_CPU));
        chk("done_d", 32'(bus.done_d), 32'(in_done && m_who == REQ_DMA));
        if (in_done && !m_we && m_who == REQ_CPU) begin
            if (!ref_unknown[m_addr]) chk("rdata_c", 32'(bus.rdata_c), 32'(ref_mem[m_addr]));
        end else begin
            chk("rdata_c_zero", 32'(bus.rdata_c), 32'd0);
        end
        if (in_done && !m_we && m_who == REQ_DMA) begin
            if (!ref_unknown[m_addr]) chk("rdata_d", 32'(bus.rdata_d), 32'(ref_mem[m_addr]));
        end else begin
            chk("rdata_d_zero", 32'(bus.rdata_d), 32'd0);
        end
        if (in_acc || in_done) chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        if (in_acc && m_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.req_c   = 1'b0;
        bus.req_d   = 1'b0;
        bus.we_c    = 1'b0;
        bus.we_d    = 1'b0;
        bus.addr_c  = '0;
        bus.addr_d  = '0;
        bus.wdata_c = '0;
        bus.wdata_d = '0;
    endtask

    task automatic drive(input req_idx_e who, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        idle_inputs();
        if (who == REQ_CPU) begin
            bus.req_c = 1'b1; bus.we_c = we; bus.addr_c = a; bus.wdata_c = d;
        end else begin
            bus.req_d = 1'b1; bus.we_d = we; bus.addr_d = a; bus.wdata_d = d;
        end
    endtask

    // Single access from idle: request one cycle, then wait out ACCESS/DONE/IDLE.
    task automatic one_access(input req_idx_e who, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        drive(who, we, a, d);
        step();
        idle_inputs();
        step();
        step();
    endtask

    int       wcount;
    req_idx_e grants[$];
    req_idx_e exp_grants[4];

    initial begin
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_done_c", 32'(bus.done_c), 32'd0);
        chk("rst_done_d", 32'(bus.done_d), 32'd0);
        chk("rst_rdata_c", 32'(bus.rdata_c), 32'd0);
        reset = 1'b0;
        step();

        // CPU read of 0x010 holding 0x5A.
        one_access(REQ_DMA, 1'b1, 12'h010, 8'h5A);
        drive(REQ_CPU, 1'b0, 12'h010, 8'h00);
        step();
        chk("cpu_rd_not_yet", 32'(bus.done_c), 32'd0);
        idle_inputs();
        step();
        chk("cpu_rd_done", 32'(bus.done_c), 32'd1);
        chk("cpu_rd_data", 32'(bus.rdata_c), 32'h5A);
        chk("cpu_rd_no_done_d", 32'(bus.done_d), 32'd0);
        step();

        // DMA write 0xA5 to 0xFFF, then CPU read back.
        drive(REQ_DMA, 1'b1, 12'hFFF, 8'hA5);
        wcount = 0;
        step();
        wcount += int'(bus.mem_write);
        idle_inputs();
        step();
        wcount += int'(bus.mem_write);
        chk("dma_wr_done", 32'(bus.done_d), 32'd1);
        chk("dma_wr_rdata", 32'(bus.rdata_d), 32'd0);
        step();
        wcount += int'(bus.mem_write);
        chk("dma_wr_pulses", 32'(wcount), 32'd1);
        drive(REQ_CPU, 1'b0, 12'hFFF, 8'h00);
        step();
        idle_inputs();
        step();
        chk("cpu_rd_fff", 32'(bus.rdata_c), 32'hA5);
        step();

        // Leave DMA as last grantee, then hold both requests.
        one_access(REQ_DMA, 1'b0, 12'h010, 8'h00);
        drive(REQ_CPU, 1'b0, 12'h010, 8'h00);
        bus.req_d  = 1'b1;
        bus.addr_d = 12'hFFF;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done_c) grants.push_back(REQ_CPU);
            if (bus.done_d) grants.push_back(REQ_DMA);
        end
        idle_inputs();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_grants = '{REQ_CPU, REQ_DMA, REQ_CPU, REQ_DMA};
`else
        exp_grants = '{REQ_CPU, REQ_CPU, REQ_CPU, REQ_CPU};
`endif
        chk("grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) chk("grant_order", 32'(grants[i]), 32'(exp_grants[i]));
        end
        step();
        step();

        // Reset during the ACCESS cycle of a write.
        one_access(REQ_CPU, 1'b1, 12'h055, 8'h3C);
        drive(REQ_CPU, 1'b1, 12'h321, 8'h77);
        step();
        reset = 1'b1;
        idle_inputs();
        step();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
        chk("abort_done_c", 32'(bus.done_c), 32'd0);
        reset = 1'b0;
        step();
        chk("abort_no_late_done", 32'(bus.done_c), 32'd0);
        drive(REQ_CPU, 1'b0, 12'h055, 8'h00);
        step();
        idle_inputs();
        step();
        chk("post_abort_done", 32'(bus.done_c), 32'd1);
        chk("post_abort_data", 32'(bus.rdata_c), 32'h3C);
        step();

        // Address change after the latch edge must not leak through.
        drive(REQ_CPU, 1'b0, 12'h100, 8'h00);
        step();
        chk("latch_addr_access", 32'(bus.mem_addr), 32'h100);
        bus.addr_c = 12'h200;
        bus.req_c  = 1'b0;
        step();
        chk("latch_addr_done", 32'(bus.mem_addr), 32'h100);
        step();

        // Randomised traffic over a small address window so reads hit earlier writes.
        for (int i = 0; i < 600; i++) begin
            bus.req_c   = ($urandom_range(0, 2) == 0);
            bus.req_d   = ($urandom_range(0, 2) == 0);
            bus.we_c    = 1'($urandom_range(0, 1));
            bus.we_d    = 1'($urandom_range(0, 1));
            bus.addr_c  = AW'($urandom_range(0, 15));
            bus.addr_d  = AW'($urandom_range(0, 15));
            bus.wdata_c = DW'($urandom);
            bus.wdata_d = DW'($urandom);
            reset       = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
